// File: rtl/serial7_pkg.sv
// serial7_pkg: shared types and frame constants
// for the serial7 receive path.
package serial7_pkg;

    localparam int DATA_BITS = 7;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

endpackage

// File: rtl/serial7_rx_sync2.sv
// sync2: two-flop synchronizer for an asynchronous
// single-bit input, resetting to a chosen level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial7_rx.sv
// serial7_rx: receives start/7 data/even parity/stop
// frames and presents the word with status pulses.
module serial7_rx
    import serial7_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sdi,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 s;
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par;

    sync2 #(
        .RST_VAL (IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sdi),
        .q   (s)
    );

    assign busy = (state != ST_IDLE);

    // frame FSM: mid-bit sampling, checks and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par        <= 1'b0;
            data       <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (s == START_LVL) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (s == START_LVL) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= s;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        par   <= s;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (s == STOP_LVL) begin
                            state <= ST_IDLE;
                            if ((^shift_reg) ^ par) begin
                                parity_err <= 1'b1;
                            end else begin
                                data     <= shift_reg;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (s == IDLE_LVL) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial7_rx.sv
// tb_serial7_rx: scoreboard-driven bench for serial7_rx
// covering good, parity-bad, framing, glitch, back-to-back, reset.
module tb_serial7_rx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       sdi;
    logic [6:0] data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] flags;
        logic [6:0] data;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [6:0] last_good;

    serial7_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sdi        (sdi),
        .data       (data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every status pulse pops one expected event
    always @(negedge clk) begin
        logic [2:0] f;
        ev_t        e;
        f = {frame_err, parity_err, rx_valid};
        if (f != 3'b000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse flags=%b data=%h cyc=%0d",
                         f, data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (f !== e.flags) begin
                    errors++;
                    $display("FAIL pulse_flags got=%b exp=%b cyc=%0d",
                             f, e.flags, cyc);
                end
                checks++;
                if (data !== e.data) begin
                    errors++;
                    $display("FAIL pulse_data got=%h exp=%h", data, e.data);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse_latency got=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // drives one frame from a negedge; returns on a negedge
    task automatic send_frame(input logic [6:0] w, input bit bad_par,
                              input bit stop_bit);
        logic [9:0] bits;
        ev_t        e;
        bits = {stop_bit, (^w) ^ bad_par, w, 1'b0};
        e.cyc = cyc + 1 + 10 * CPB;
        if (!stop_bit) begin
            e.flags = 3'b100;
            e.data  = last_good;
        end else if (bad_par) begin
            e.flags = 3'b010;
            e.data  = last_good;
        end else begin
            e.flags   = 3'b001;
            e.data    = w;
            last_good = w;
        end
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            sdi = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_sb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sdi = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data, rx_valid, parity_err, frame_err, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {data, rx_valid, parity_err, frame_err, busy});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data, busy} !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_idle got=%h exp=0", {data, busy});
        end
        last_good = 7'h00;
    endtask

    task automatic test_good;
        bit ok;
        send_frame(7'h55, 1'b0, 1'b1);
        wait_sb(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL good_timeout pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_parity;
        bit ok;
        send_frame(7'h7F, 1'b1, 1'b1);
        wait_sb(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL parity_timeout pending=%0d exp=0", exp_q.size());
        end
        checks++;
        if (data !== 7'h55) begin
            errors++;
            $display("FAIL parity_data_kept got=%h exp=55", data);
        end
    endtask

    task automatic test_frame;
        bit ok;
        int low_busy;
        low_busy = 0;
        send_frame(7'h01, 1'b0, 1'b0);
        sdi = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) low_busy++;
        end
        checks++;
        if (low_busy != 0) begin
            errors++;
            $display("FAIL break_busy idle_cycles=%0d exp=0", low_busy);
        end
        sdi = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL break_hold got=%b exp=1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL break_exit got=%b exp=0", busy);
        end
        wait_sb(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_timeout pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_glitch;
        int hi;
        hi = 0;
        sdi = 1'b0;
        @(negedge clk);
        sdi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) hi++;
            @(negedge clk);
        end
        checks++;
        if (hi < 1 || hi > 4) begin
            errors++;
            $display("FAIL glitch_busy cycles=%0d exp=1..4", hi);
        end
        checks++;
        if ({busy, data} !== {1'b0, last_good}) begin
            errors++;
            $display("FAIL glitch_state got=%h exp=%h",
                     {busy, data}, {1'b0, last_good});
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        send_frame(7'h12, 1'b0, 1'b1);
        send_frame(7'h6D, 1'b0, 1'b1);
        wait_sb(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout pending=%0d exp=0", exp_q.size());
        end
        checks++;
        if (data !== 7'h6D) begin
            errors++;
            $display("FAIL b2b_data got=%h exp=6d", data);
        end
    endtask

    task automatic test_reset_mid;
        bit         ok;
        logic [9:0] bits;
        logic [6:0] w;
        w    = 7'h33;
        bits = {1'b1, ^w, w, 1'b0};
        for (int i = 0; i < 4; i++) begin
            sdi = bits[i];
            repeat (CPB) @(negedge clk);
        end
        sdi = bits[4];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sdi = 1'b1;
        #1;
        checks++;
        if ({data, rx_valid, parity_err, frame_err, busy} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0",
                     {data, rx_valid, parity_err, frame_err, busy});
        end
        last_good = 7'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if ({busy, data} !== 8'd0) begin
            errors++;
            $display("FAIL aborted_frame got=%h exp=0", {busy, data});
        end
        send_frame(7'h2A, 1'b0, 1'b1);
        wait_sb(ok);
        checks++;
        if (!ok || data !== 7'h2A) begin
            errors++;
            $display("FAIL after_reset got=%h exp=2a ok=%0d", data, ok);
        end
    endtask

    initial begin
        rst = 1'b1;
        sdi = 1'b1;
        last_good = 7'h00;
        @(negedge clk);
        test_reset();
        test_good();
        test_parity();
        test_frame();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
